quad_decoder: RTL

Quadrature decoder for a rotary or incremental encoder wired to two header pins on the Mimas V2 board. It synchronises and debounces the A/B channels and decodes every valid Gray-code transition into an up or down step. It keeps a wrapping position count for the LED bank. It is the input-side counterpart of the switch-driven up/down counter: the count direction and rate come from a physical encoder instead of a slide switch and clock divider.

---
 rtl/quad_pkg.sv | 56 +++++
 rtl/quad_decoder_debounce.sv | 53 +++++
 rtl/quad_decoder.sv | 109 ++++++++++
 3 files changed

// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature decoder: FSM states,
// direction codes, Gray phases and the transition classifier.
`default_nettype none

package quad_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    TR_NONE = 2'd0,
    TR_UP   = 2'd1,
    TR_DN   = 2'd2,
    TR_ERR  = 2'd3
  } trans_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Phases are {A,B}; the up sequence visits them in this order.
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  function automatic logic [1:0] next_up(input logic [1:0] ph);
    logic [1:0] nxt;
    nxt = PH_00;
    case (ph)
      PH_00:   nxt = PH_10;
      PH_10:   nxt = PH_11;
      PH_11:   nxt = PH_01;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

  function automatic trans_t classify(input logic [1:0] prev, input logic [1:0] cur);
    trans_t t;
    if (prev == cur) begin
      t = TR_NONE;
    end else if ((prev ^ cur) == 2'b11) begin
      t = TR_ERR;
    end else if (next_up(prev) == cur) begin
      t = TR_UP;
    end else begin
      t = TR_DN;
    end
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/quad_decoder_debounce.sv
// One encoder channel: two-flop synchroniser followed by a stability filter
// that accepts a new level only after DEB_CYCLES consecutive differing samples.
`default_nettype none

module debounce #(
  parameter int DEB_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic filt_o
);

  localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

  logic        sync1_q;
  logic        sync2_q;
  logic        filt_q;
  logic        filt_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == DEB_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

`default_nettype wire

// File: rtl/quad_decoder.sv
// Quadrature decoder top: debounced A/B channels, INIT/RUN FSM, x4 Gray-code
// decode into a wrapping position count with step/dir pulses and sticky error.
`default_nettype none

module quad_decoder
  import quad_pkg::*;
#(
  parameter int DEB_CYCLES = 1000,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  output logic [CNT_W-1:0] q,
  output logic             step,
  output logic             dir,
  output logic             err
);

  // One cycle beyond the filter latency so that prev captures a channel that
  // was already active at reset release before decoding starts.
  localparam logic [16:0] INIT_LAST = 17'(DEB_CYCLES + 2);

  logic             a_filt;
  logic             b_filt;
  logic [1:0]       phase;
  trans_t           trans;

  state_t           state_q;
  logic [16:0]      init_cnt_q;
  logic [1:0]       prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic             step_q;
  logic             dir_q;
  logic             err_q;

  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (a_in),
    .filt_o (a_filt)
  );

  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (b_in),
    .filt_o (b_filt)
  );

  assign phase = {a_filt, b_filt};
  assign trans = classify(prev_q, phase);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      prev_q     <= PH_00;
      cnt_q      <= '0;
      step_q     <= 1'b0;
      dir_q      <= DIR_DN;
      err_q      <= 1'b0;
    end else begin
      prev_q <= phase;
      step_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          if (init_cnt_q == INIT_LAST) begin
            state_q <= ST_RUN;
          end else begin
            init_cnt_q <= init_cnt_q + 17'd1;
          end
        end
        ST_RUN: begin
          case (trans)
            TR_UP: begin
              cnt_q  <= cnt_q + CNT_W'(1);
              dir_q  <= DIR_UP;
              step_q <= 1'b1;
            end
            TR_DN: begin
              cnt_q  <= cnt_q - CNT_W'(1);
              dir_q  <= DIR_DN;
              step_q <= 1'b1;
            end
            TR_ERR:  err_q <= 1'b1;
            default: ;
          endcase
        end
        default: state_q <= ST_INIT;
      endcase
      // Clear wins over a same-cycle count or error; step/dir still report it.
      if (clr) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end
    end
  end

  assign q    = cnt_q;
  assign step = step_q;
  assign dir  = dir_q;
  assign err  = err_q;

endmodule

`default_nettype wire
